// File: rtl/fixed_pkg.sv
// Shared Q10.10 constants and the power FSM state encoding.
// The root engine uses the same Q constants.
package fixed_pkg;

   localparam int DATA_W = 20;
   localparam int FRAC_W = 10;
   localparam int EXP_W  = 3;

   localparam logic [DATA_W-1:0] Q_ONE = 20'h00400;
   localparam logic [DATA_W-1:0] Q_SAT = 20'hFFFFF;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_MUL    = 2'd1,
      S_DONE   = 2'd2,
      S_OUTPUT = 2'd3
   } pwr_state_t;

endpackage

// File: rtl/q_mul_sat.sv
// Combinational unsigned Q10.10 multiply: truncates the fraction and clamps
// to full scale, flagging overflow.
module q_mul_sat
   import fixed_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] q,
   output logic              ovf
);

   logic [2*DATA_W-1:0] prod;
   logic [2*DATA_W-1:0] prod_sh;

   always_comb begin
      prod    = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
      prod_sh = prod >> FRAC_W;
      // Any bit above the Q10.10 range means the truncated value exceeds Q_SAT.
      ovf     = |prod_sh[2*DATA_W-1:DATA_W];
      q       = ovf ? Q_SAT : prod_sh[DATA_W-1:0];
   end

endmodule

// File: rtl/fixed_power.sv
// Sequential Q10.10 integer power: out = base ^ k, k in 0..7, one multiply
// per cycle with early exit when the running product saturates.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for in_valid; latch operands, acc = 1.0
// S_MUL    | acc = trunc(acc * base); leave on last step or on saturation
// S_DONE   | register the result into the output stage
// S_OUTPUT | out_valid pulse cycle; back to idle
module fixed_power
   import fixed_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data_1,
   input  logic [EXP_W-1:0]  in_data_2,
   output logic              busy,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sat
);

   pwr_state_t        state;
   pwr_state_t        state_nxt;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] base_r;
   logic [EXP_W-1:0]  exp_r;
   logic [EXP_W-1:0]  cnt;
   logic [EXP_W-1:0]  cnt_inc;
   logic              sat_r;
   logic [DATA_W-1:0] mul_q;
   logic              mul_ovf;

   q_mul_sat u_mul (
      .a   (acc),
      .b   (base_r),
      .q   (mul_q),
      .ovf (mul_ovf)
   );

   always_comb begin
      cnt_inc   = cnt + 1'b1;
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (in_valid) begin
               state_nxt = (in_data_2 != '0) ? S_MUL : S_DONE;
            end
         end
         S_MUL: begin
            if (mul_ovf || (cnt_inc == exp_r)) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE:   state_nxt = S_OUTPUT;
         S_OUTPUT: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state     <= S_IDLE;
         acc       <= '0;
         base_r    <= '0;
         exp_r     <= '0;
         cnt       <= '0;
         sat_r     <= 1'b0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else begin
         state     <= state_nxt;
         busy      <= (state_nxt != S_IDLE);
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  base_r <= in_data_1;
                  exp_r  <= in_data_2;
                  acc    <= Q_ONE;
                  cnt    <= '0;
                  sat_r  <= 1'b0;
               end
            end
            S_MUL: begin
               // Saturation is sticky: acc pins at full scale and the loop ends.
               if (mul_ovf) begin
                  acc   <= Q_SAT;
                  sat_r <= 1'b1;
               end else begin
                  acc <= mul_q;
                  cnt <= cnt_inc;
               end
            end
            S_DONE: begin
               out_valid <= 1'b1;
               out_data  <= acc;
               out_sat   <= sat_r;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fixed_power.sv
// Scoreboard bench for fixed_power: drivers push expected results with the
// cycle they must appear in; a negedge monitor pops and compares.
module tb_fixed_power;
   import fixed_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic [DATA_W-1:0] in_data_1;
   logic [EXP_W-1:0]  in_data_2;
   logic              busy;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_sat;

   fixed_power dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data_1 (in_data_1),
      .in_data_2 (in_data_2),
      .busy      (busy),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sat   (out_sat)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              sat;
      int                cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   b_lo     = 1;
   int   b_hi     = 0;
   bit   chk_en   = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
   endtask

   function automatic void ref_pow(input logic [DATA_W-1:0] b, input logic [EXP_W-1:0] k,
                                   output logic [DATA_W-1:0] d, output logic s, output int lat);
      logic [63:0] a;
      a   = 64'd1024;
      s   = 1'b0;
      lat = 2;
      for (int i = 1; i <= int'(k); i++) begin
         a   = (a * b) >> 10;
         lat = i + 2;
         if (a > 64'hFFFFF) begin
            a = 64'hFFFFF;
            s = 1'b1;
            break;
         end
      end
      d = a[DATA_W-1:0];
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (chk_en) begin
         check("busy", busy, (cyc >= b_lo && cyc <= b_hi));
         if (out_valid) begin
            if (sb.size() == 0) begin
               check("unexpected out_valid", out_valid, 1'b0);
            end else begin
               e = sb.pop_front();
               check("out_data", out_data, e.data);
               check("out_sat", out_sat, e.sat);
               check("out_valid cycle", cyc, e.cyc);
            end
         end else begin
            check("idle out_data", out_data, '0);
            check("idle out_sat", out_sat, 1'b0);
         end
      end
   end

   task automatic issue(input logic [DATA_W-1:0] b, input logic [EXP_W-1:0] k,
                        input logic [DATA_W-1:0] d, input logic s, input int lat);
      @(negedge clk);
      in_valid  = 1'b1;
      in_data_1 = b;
      in_data_2 = k;
      sb.push_back('{data: d, sat: s, cyc: cyc + lat});
      b_lo = cyc + 1;
      b_hi = cyc + lat;
      @(negedge clk);
      in_valid  = 1'b0;
      in_data_1 = 20'h5A5A5;
      in_data_2 = 3'd6;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("drain timeout", sb.size(), 0);
      sb.delete();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int                next_free;
      logic [DATA_W-1:0] rd;
      logic              rs;
      int                rl;

      rst_n     = 1'b1;
      in_valid  = 1'b0;
      in_data_1 = '0;
      in_data_2 = '0;
      repeat (3) @(negedge clk);
      rst_n  = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);

      // base, k, expected data, expected sat, latency
      issue(20'h00800, 3'd3, 20'h02000, 1'b0, 5); wait_idle();
      issue(20'h00600, 3'd2, 20'h00900, 1'b0, 4); wait_idle();
      issue(20'h00200, 3'd7, 20'h00008, 1'b0, 9); wait_idle();
      issue(20'h12345, 3'd0, 20'h00400, 1'b0, 2); wait_idle();
      issue(20'h00000, 3'd5, 20'h00000, 1'b0, 7); wait_idle();
      issue(20'h0A000, 3'd4, 20'hFFFFF, 1'b1, 4); wait_idle();
      issue(20'h00401, 3'd3, 20'h00403, 1'b0, 5); wait_idle();
      issue(20'hFFFFF, 3'd1, 20'hFFFFF, 1'b0, 3); wait_idle();

      // in_valid held high; only requests seen while idle count
      next_free = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         in_valid  = 1'b1;
         in_data_1 = 20'h00300 + DATA_W'(i) * 20'h00111;
         in_data_2 = EXP_W'(i % 4);
         if (cyc >= next_free) begin
            ref_pow(in_data_1, in_data_2, rd, rs, rl);
            sb.push_back('{data: rd, sat: rs, cyc: cyc + rl});
            b_lo      = cyc + 1;
            b_hi      = cyc + rl;
            next_free = cyc + rl + 1;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      wait_idle();

      // reset two cycles into a k=7 operation
      @(negedge clk);
      in_valid  = 1'b1;
      in_data_1 = 20'h00800;
      in_data_2 = 3'd7;
      sb.push_back('{data: 20'h20000, sat: 1'b0, cyc: cyc + 9});
      b_lo = cyc + 1;
      b_hi = cyc + 9;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      b_hi = cyc;
      @(negedge clk);
      check("post-reset out_valid", out_valid, 1'b0);
      check("post-reset busy", busy, 1'b0);
      check("post-reset out_data", out_data, '0);
      check("post-reset out_sat", out_sat, 1'b0);
      rst_n = 1'b0;
      repeat (12) @(negedge clk);

      issue(20'h00800, 3'd7, 20'h20000, 1'b0, 9); wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
